// File: rtl/rr_arb_4_2.sv
// Four-requester round-robin arbiter with registered one-hot grant plus {valid, index} encoding.
// Latency: request sampled at one edge is granted after that edge; release hands off on the same edge.
// Backpressure: the owner keeps the grant while its req stays high; RR_ARB_TIMEOUT_EN adds a forced hand-off after MAX_HOLD cycles.
module rr_arb_4_2 #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_v,
    output logic       preempt
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nxt;
    logic [1:0] last, last_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] id_nxt;
    logic       v_nxt;
    logic       new_grant;

    logic       found;
    logic [1:0] win;
    logic [1:0] cand;
    logic       owner_req;
    logic       others;
    logic       force_hand;

    assign owner_req = req[gnt_id];
    assign others    = |(req & ~gnt);

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;

    assign force_hand = (state == BUSY) && (hold_cnt == HOLD_LIM) && others;

    // Hold counter: cleared on each grant, counts ownership cycles, saturates at 255.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else if (new_grant) begin
            hold_cnt <= 8'd0;
        end else if (state == BUSY && hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

    // Preempt flags the first cycle of a grant taken from an owner that still requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preempt <= 1'b0;
        end else begin
            preempt <= force_hand && owner_req;
        end
    end
`else
    logic unused_cfg;

    assign force_hand = 1'b0;
    assign preempt    = 1'b0;
    assign unused_cfg = ^8'(MAX_HOLD);
`endif

    // Round-robin search: last+1, last+2, last+3, last; the previous owner is tried last.
    always_comb begin
        found = 1'b0;
        win   = last;
        cand  = last;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and next-grant decision.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        id_nxt    = gnt_id;
        v_nxt     = gnt_v;
        last_nxt  = last;
        new_grant = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    new_grant = 1'b1;
                end
            end
            BUSY: begin
                if (!owner_req || force_hand) begin
                    if (found) begin
                        new_grant = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        id_nxt    = 2'd0;
                        v_nxt     = 1'b0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (new_grant) begin
            state_nxt = BUSY;
            gnt_nxt   = 4'b0001 << win;
            id_nxt    = win;
            v_nxt     = 1'b1;
            last_nxt  = win;
        end
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last   <= 2'd3;
            gnt    <= 4'b0000;
            gnt_id <= 2'd0;
            gnt_v  <= 1'b0;
        end else begin
            state  <= state_nxt;
            last   <= last_nxt;
            gnt    <= gnt_nxt;
            gnt_id <= id_nxt;
            gnt_v  <= v_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arb_4_2.sv
// Self-checking bench for rr_arb_4_2: directed vector table, hand-written corner sequences,
// then randomized requests checked against an ownership-level reference model.
module tb_rr_arb_4_2;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int TB_MAX_HOLD = 4;
`else
    localparam int TB_MAX_HOLD = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_v;
    logic       preempt;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model state: owner index (-1 = idle), last owner, hold count, preempt flag.
    int m_owner;
    int m_last;
    int m_hold;
    bit m_pre;

    typedef struct {
        bit         do_rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       v;
        string      nm;
    } vec_t;

    vec_t tbl[$];

    rr_arb_4_2 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .gnt_v   (gnt_v),
        .preempt (preempt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [3:0] eg, input logic [1:0] eid,
                       input logic ev, input logic ep);
        n_chk++;
        if (gnt !== eg || gnt_id !== eid || gnt_v !== ev || preempt !== ep) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b id=%0d v=%b pre=%b, want gnt=%b id=%0d v=%b pre=%b",
                     nm, gnt, gnt_id, gnt_v, preempt, eg, eid, ev, ep);
        end
    endtask

    function automatic int pick(input logic [3:0] r, input int lst);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (lst + k) % 4;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = 3;
        m_hold  = 0;
        m_pre   = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        bit tmo;
        m_pre = 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_hold  = 0;
            end
        end else begin
            tmo = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            tmo = (m_hold == TB_MAX_HOLD - 1) && ((r & ~(4'b0001 << m_owner)) != 4'b0000);
`endif
            if (!r[m_owner] || tmo) begin
                w = pick(r, m_last);
                if (w >= 0) begin
                    m_pre   = r[m_owner];
                    m_owner = w;
                    m_last  = w;
                    m_hold  = 0;
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end
    endtask

    task automatic chk_model(input string nm);
        logic [3:0] eg;
        logic [1:0] eid;
        eg  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        eid = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        chk(nm, eg, eid, m_owner >= 0, m_pre);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        rst = 1'b1;
        #2;
        chk("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Apply req, clock once, advance the model, leave time 1 after the edge.
    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic add(input bit dr, input logic [3:0] r, input logic [3:0] g,
                       input logic [1:0] id, input logic v, input string nm);
        vec_t e;
        e.do_rst = dr; e.req = r; e.gnt = g; e.id = id; e.v = v; e.nm = nm;
        tbl.push_back(e);
    endtask

    initial begin
        logic [3:0] r;

        // Single requester, then release.
        add(1, 4'b0100, 4'b0100, 2'd2, 1, "single_gnt");
        add(0, 4'b0000, 4'b0000, 2'd0, 0, "single_rel");
        // All four from reset, 3 cycles each, back-to-back hand-offs.
        add(1, 4'b1111, 4'b0001, 2'd0, 1, "order_0a");
        add(0, 4'b1111, 4'b0001, 2'd0, 1, "order_0b");
        add(0, 4'b1111, 4'b0001, 2'd0, 1, "order_0c");
        add(0, 4'b1110, 4'b0010, 2'd1, 1, "order_1a");
        add(0, 4'b1110, 4'b0010, 2'd1, 1, "order_1b");
        add(0, 4'b1110, 4'b0010, 2'd1, 1, "order_1c");
        add(0, 4'b1100, 4'b0100, 2'd2, 1, "order_2a");
        add(0, 4'b1100, 4'b0100, 2'd2, 1, "order_2b");
        add(0, 4'b1100, 4'b0100, 2'd2, 1, "order_2c");
        add(0, 4'b1000, 4'b1000, 2'd3, 1, "order_3a");
        add(0, 4'b1000, 4'b1000, 2'd3, 1, "order_3b");
        add(0, 4'b1000, 4'b1000, 2'd3, 1, "order_3c");
        add(0, 4'b0000, 4'b0000, 2'd0, 0, "order_idle");
        // Fairness: owner 1 releases with 0 and 3 waiting -> 3 before 0.
        add(1, 4'b0010, 4'b0010, 2'd1, 1, "fair_own1");
        add(0, 4'b1011, 4'b0010, 2'd1, 1, "fair_hold1");
        add(0, 4'b1001, 4'b1000, 2'd3, 1, "fair_to3");
        add(0, 4'b0001, 4'b0001, 2'd0, 1, "fair_to0");
        add(0, 4'b0000, 4'b0000, 2'd0, 0, "fair_idle");

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_rst) do_reset();
            cyc(tbl[i].req);
            chk(tbl[i].nm, tbl[i].gnt, tbl[i].id, tbl[i].v, 1'b0);
        end

        // Asynchronous reset between edges clears the grant at once.
        do_reset();
        cyc(4'b0010);
        chk("arst_pre", 4'b0010, 2'd1, 1'b1, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_immediate", 4'b0000, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        model_reset();
        cyc(4'b1100);
        chk("arst_after", 4'b0100, 2'd2, 1'b1, 1'b0);

        // Competitor arrives while owner 0 keeps requesting.
        do_reset();
        cyc(4'b0001);
        chk("tmo_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
`ifdef RR_ARB_TIMEOUT_EN
        cyc(4'b0101); chk("tmo_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b0101); chk("tmo_hold3", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b0101); chk("tmo_hold4", 4'b0001, 2'd0, 1'b1, 1'b0);
        cyc(4'b0101); chk("tmo_preempt", 4'b0100, 2'd2, 1'b1, 1'b1);
        cyc(4'b0101); chk("tmo_pulse_end", 4'b0100, 2'd2, 1'b1, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            cyc(4'b0101);
            chk("no_tmo_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end
`endif

        // Lone requester held for 300 cycles: never loses the grant.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            cyc(4'b0001);
            chk("lone_hold", 4'b0001, 2'd0, 1'b1, 1'b0);
        end

        // Randomized requests against the reference model.
        do_reset();
        r = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                r = 4'($urandom_range(0, 15));
            end else if ($urandom_range(0, 2) == 0) begin
                r[$urandom_range(0, 3)] ^= 1'b1;
            end
            cyc(r);
            chk_model("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
